gpio_in_cond: RTL
=================

Name: gpio_in_cond

Overview:
Input conditioning stage directly upstream of the GPIO controller's input port (control register 0). Per channel, it synchronises raw asynchronous pins, debounces them with a counter FSM, and drives the clean `gpio_in` vector the GPIO block samples. It also produces one-cycle edge pulses and a sticky, maskable interrupt status for the interrupt controller.

Parameters:
- CH, 8, number of input channels (1..32, must equal the GPIO input channel count).
- SYNC_STAGES, 2, synchroniser flop depth (>= 2).
- DB_CNT_W, 16, debounce counter width.
- DB_LIMIT, 50000, consecutive stable cycles required to accept a new level (1 .. 2^DB_CNT_W-1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pin_in  in  CH  raw asynchronous pad inputs
- gpio_in  out  CH  debounced levels, fed to the GPIO controller's gpio_in
- rise_pulse  out  CH  one-cycle pulse on accepted 0->1
- fall_pulse  out  CH  one-cycle pulse on accepted 1->0
- irq_mask  in  CH  1 = accepted edge sets irq_stat bit
- irq_clr  in  CH  write-one-to-clear strobe for irq_stat
- irq_stat  out  CH  sticky edge status
- irq  out  1  OR-reduction of irq_stat (combinational from irq_stat flops)

Behaviour:
- Reset applies on any clk edge with reset=1 and overrides all other activity, including a count in progress. It clears:
  - synchroniser flops
  - counters
  - FSM (to STABLE)
  - gpio_in, rise_pulse, fall_pulse and irq_stat (all 0), so irq=0.
- Synchroniser: SYNC_STAGES flops per channel. `sync` denotes the last stage.
- Per-channel FSM, states STABLE and COUNT:
  - STABLE: if sync != gpio_in, go to COUNT with cnt=1; otherwise cnt=0.
  - COUNT, sync == gpio_in (glitch ended): go to STABLE, cnt=0, no output change.
  - COUNT, sync != gpio_in and cnt == DB_LIMIT-1: on this edge, gpio_in<=sync, pulse the matching edge output, go to STABLE, cnt=0.
  - COUNT otherwise: cnt<=cnt+1.
  - DB_LIMIT=1: the level is accepted on the first cycle sync differs; the FSM passes through COUNT for 0 cycles, i.e. STABLE performs the update directly.
- Latency: a pin level held steadily is reflected on gpio_in exactly SYNC_STAGES+DB_LIMIT rising edges after the first edge that samples it. Any pulse shorter than DB_LIMIT cycles (post-sync) is discarded.
- rise_pulse/fall_pulse are registered. They are high for exactly the cycle gpio_in first shows the new value; never both high on one channel.
- Counter never wraps: the maximum value reached is DB_LIMIT-1.
- irq_stat[i] update, next edge:
  - sets if an accepted edge occurs and irq_mask[i]=1
  - else clears if irq_clr[i]=1
  - set wins over a simultaneous clear.
  - Masking an already-set bit does not clear it.
- After reset with a pin held high, gpio_in rises after the full latency and produces a rise_pulse (intended: software sees a defined power-up edge).

Optional Feature:
Macro GPIO_IN_EDGE_SEL_EN.
- Defined: adds input irq_edge[CH] (1 = rising sets irq_stat, 0 = falling sets irq_stat).
- Undefined: port absent; both edges set irq_stat when masked in.
- rise_pulse/fall_pulse are unaffected either way.

Decomposition:
- Shared header gpio_in_cond.h:
  - FSM state encodings (GPIO_IN_ST_STABLE=1'b0, GPIO_IN_ST_COUNT=1'b1)
  - default DB_LIMIT/DB_CNT_W
  - edge-select encodings (GPIO_IN_EDGE_RISE=1'b1, GPIO_IN_EDGE_FALL=1'b0)
- Sub-module gpio_in_cond_ch: one channel's synchroniser, counter, FSM and pulses, instantiated CH times via generate.
- The top level holds irq_stat logic and the irq OR.

Test Plan:
All scenarios use CH=8, SYNC_STAGES=2, DB_LIMIT=4.
1. Reset with pin_in=8'h00 held 10 cycles -> all outputs 0, irq=0. Then pin_in=8'h00 steady 20 cycles -> no pulses.
2. irq_mask=8'h01, pin_in[0] 0->1 sampled at edge T -> gpio_in[0]=1 and rise_pulse[0]=1 at edge T+5 (6th edge, counting T as 1st), pulse low at T+6. irq_stat[0]=1 and irq=1 from edge T+6.
3. pin_in[1] high for 3 cycles then low -> gpio_in[1] stays 0, no rise/fall pulse. A repeated 5-cycle high -> rises, then after the fall the accepted 1->0 gives a fall_pulse[1].
4. irq_mask=8'h00, edge on ch2 -> rise_pulse[2] fires, irq_stat stays 8'h00. Then irq_clr=8'h01 on a set ch0 bit with no new edge -> bit clears next edge, irq=0.
5. irq_clr[0]=1 in the same cycle as an accepted masked edge on ch0 -> irq_stat[0] remains 1.
6. Reset asserted at count 2 of a ch3 rise with pin held high -> all state cleared. After reset deasserts, gpio_in[3] rises exactly 6 edges later with rise_pulse[3]. With GPIO_IN_EDGE_SEL_EN defined and irq_edge[3]=0, irq_stat[3] stays 0 on that rise and sets on the following accepted fall.

Source files
------------

// File: rtl/gpio_in_cond_pkg.sv
// -----------------------------------------------------------------------------
// gpio_in_cond_pkg
// Shared definitions for the GPIO input conditioning slice:
//   - debounce FSM state encoding
//   - default debounce counter width / limit
//   - irq edge-select encoding and a helper that applies it
// -----------------------------------------------------------------------------
package gpio_in_cond_pkg;

    typedef enum logic {
        GPIO_IN_ST_STABLE = 1'b0,
        GPIO_IN_ST_COUNT  = 1'b1
    } gpio_in_state_e;

    localparam int GPIO_IN_DEF_DB_CNT_W = 16;
    localparam int GPIO_IN_DEF_DB_LIMIT = 50000;

    localparam logic GPIO_IN_EDGE_RISE = 1'b1;
    localparam logic GPIO_IN_EDGE_FALL = 1'b0;

    // True when the accepted edge matches the selected polarity.
    function automatic logic edge_hit(input logic sel, input logic rise, input logic fall);
        return ((sel == GPIO_IN_EDGE_RISE) && rise) || ((sel == GPIO_IN_EDGE_FALL) && fall);
    endfunction

endpackage

// File: rtl/gpio_in_cond_ch.sv
// -----------------------------------------------------------------------------
// gpio_in_cond_ch
// One input channel: SYNC_STAGES-deep synchroniser, debounce counter FSM,
// registered debounced level and one-cycle rise/fall pulses.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_pin        raw asynchronous pad input
//   o_level      debounced level
//   o_rise       one-cycle pulse when a 0->1 change is accepted
//   o_fall       one-cycle pulse when a 1->0 change is accepted
// -----------------------------------------------------------------------------
module gpio_in_cond_ch
    import gpio_in_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = GPIO_IN_DEF_DB_CNT_W,
    parameter int DB_LIMIT    = GPIO_IN_DEF_DB_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [DB_CNT_W-1:0] LIMIT_M1 = DB_CNT_W'(DB_LIMIT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    gpio_in_state_e         r_state;
    gpio_in_state_e         w_state_nxt;
    logic [DB_CNT_W-1:0]    r_cnt;
    logic [DB_CNT_W-1:0]    w_cnt_nxt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;
    logic                   w_diff;
    logic                   w_accept;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_diff  = w_sync ^ r_level;
    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_state <= GPIO_IN_ST_STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_accept ? w_sync : r_level;
            r_rise  <= w_accept & w_sync;
            r_fall  <= w_accept & ~w_sync;
        end
    end

    // The counter holds the number of consecutive differing cycles already
    // seen; the change is accepted on the DB_LIMIT-th one. With DB_LIMIT=1
    // the very first differing cycle is accepted straight from STABLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            GPIO_IN_ST_STABLE: begin
                w_cnt_nxt = '0;
                if (w_diff) begin
                    if (DB_LIMIT == 1) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_nxt = GPIO_IN_ST_COUNT;
                        w_cnt_nxt   = DB_CNT_W'(1);
                    end
                end
            end
            GPIO_IN_ST_COUNT: begin
                if (!w_diff) begin
                    w_state_nxt = GPIO_IN_ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LIMIT_M1) begin
                    w_accept    = 1'b1;
                    w_state_nxt = GPIO_IN_ST_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + DB_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = GPIO_IN_ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/gpio_in_cond.sv
// -----------------------------------------------------------------------------
// gpio_in_cond
// Input conditioning ahead of the GPIO controller: per-channel synchronise +
// debounce (gpio_in_cond_ch), edge pulses, and a sticky maskable irq status.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   pin_in       raw asynchronous pad inputs
//   gpio_in      debounced levels
//   rise_pulse   one-cycle pulse per accepted 0->1
//   fall_pulse   one-cycle pulse per accepted 1->0
//   irq_mask     1 = accepted edge sets the irq_stat bit
//   irq_clr      write-one-to-clear strobe for irq_stat
//   irq_edge     (GPIO_IN_EDGE_SEL_EN only) 1 = rising, 0 = falling sets status
//   irq_stat     sticky edge status
//   irq          OR of irq_stat
// Build option: define GPIO_IN_EDGE_SEL_EN to add per-channel edge selection;
// otherwise both edges set irq_stat.
// -----------------------------------------------------------------------------
module gpio_in_cond
    import gpio_in_cond_pkg::*;
#(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = GPIO_IN_DEF_DB_CNT_W,
    parameter int DB_LIMIT    = GPIO_IN_DEF_DB_LIMIT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] pin_in,
    output logic [CH-1:0] gpio_in,
    output logic [CH-1:0] rise_pulse,
    output logic [CH-1:0] fall_pulse,
    input  logic [CH-1:0] irq_mask,
    input  logic [CH-1:0] irq_clr,
`ifdef GPIO_IN_EDGE_SEL_EN
    input  logic [CH-1:0] irq_edge,
`endif
    output logic [CH-1:0] irq_stat,
    output logic          irq
);

    logic [CH-1:0] r_irq_stat;
    logic [CH-1:0] w_edge_set;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        gpio_in_cond_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CNT_W    (DB_CNT_W),
            .DB_LIMIT    (DB_LIMIT)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_pin   (pin_in[g]),
            .o_level (gpio_in[g]),
            .o_rise  (rise_pulse[g]),
            .o_fall  (fall_pulse[g])
        );
    end

    always_comb begin
        w_edge_set = '0;
        for (int unsigned i = 0; i < CH; i++) begin
`ifdef GPIO_IN_EDGE_SEL_EN
            w_edge_set[i] = edge_hit(irq_edge[i], rise_pulse[i], fall_pulse[i]);
`else
            w_edge_set[i] = rise_pulse[i] | fall_pulse[i];
`endif
        end
    end

    // Set has priority over a same-cycle clear; the mask only gates new sets.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_stat <= '0;
        end else begin
            r_irq_stat <= (r_irq_stat & ~irq_clr) | (w_edge_set & irq_mask);
        end
    end

    assign irq_stat = r_irq_stat;
    assign irq      = |r_irq_stat;

endmodule
